// File: rtl/sram_like_bridge_if.sv
// CPU data-port and sram-like system-bus signal bundle for sram_like_bridge.
// master = bridge view, slave = CPU core / bus slave view.
interface sram_like_bridge_if;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall_other;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, cpu_stall_other,
    output cpu_rdata, cpu_stall,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_err,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output cpu_en, cpu_wen, cpu_addr, cpu_wdata, cpu_stall_other,
    input  cpu_rdata, cpu_stall,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_err,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_like_bridge.sv
// CPU SRAM-style data port to sram-like bus bridge: one bus transaction per access, stall until data phase done.
// Optional fixed kseg0/kseg1 translation under `define ADDR_XLATE_EN.
module sram_like_bridge #(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  sram_like_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_e            state_q;
  logic              req_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        size;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cpu_en) begin
          state_q <= ADDR;
          req_q   <= 1'b1;
          cnt_q   <= '0;
        end
        ADDR: if (bus.bus_addr_ok) begin
          state_q <= DATA;
          req_q   <= 1'b0;
        end
        DATA: if (bus.bus_data_ok) begin
          state_q <= DONE;
          rdata_q <= bus.bus_rdata;
        end
        DONE: if (!bus.cpu_stall_other) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      // Watchdog saturates at TIMEOUT; the FSM is never forced out of ADDR/DATA.
      if (TIMEOUT > 0 && (state_q == ADDR || state_q == DATA) && cnt_q != TO) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q + 1'b1 == TO) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    size = 2'd2;
    case (bus.cpu_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
      4'b0011, 4'b1100:                   size = 2'd1;
      default:                            size = 2'd2;
    endcase
  end

  assign bus.cpu_stall = bus.cpu_en & (state_q != DONE);
  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_err   = err_q;
  assign bus.bus_wr    = |bus.cpu_wen;
  assign bus.bus_size  = size;
  assign bus.bus_wdata = bus.cpu_wdata;
`ifdef ADDR_XLATE_EN
  assign bus.bus_addr  = (bus.cpu_addr[31:30] == 2'b10) ? {3'b000, bus.cpu_addr[28:0]} : bus.cpu_addr;
`else
  assign bus.bus_addr  = bus.cpu_addr;
`endif
endmodule
